mem_arbiter_ctrl: RTL and testbench
===================================

Name: mem_arbiter_ctrl

Overview:
- CPU-side memory controller sitting directly downstream of the CPU top level.
- Consumes the CPU's instruction-fetch port (instruction address) and data port (address, write enable, write data).
- Arbitrates both ports onto one single-ported backing-memory bus with a req/ack handshake and variable latency.
- Returns read data plus one-cycle completion pulses; the CPU stalls while a completion pulse is absent.

Parameters:
- TIMEOUT, 255, max cycles bus_req may wait for bus_ack before abort; 0 disables the timeout.
- ERR_DATA, 32'h0000_0000, read data returned on a timed-out read.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- cpu_instr_req  input  1  fetch request, held until cpu_instr_valid
- cpu_instr_addr  input  32  fetch byte address
- cpu_instr_data  output  32  fetched instruction
- cpu_instr_valid  output  1  one-cycle fetch completion pulse
- cpu_rd  input  1  data read request
- cpu_wr  input  1  data write request
- cpu_addr  input  32  data byte address
- cpu_wr_data  input  32  write data
- cpu_rd_data  output  32  read data
- cpu_valid  output  1  one-cycle data completion pulse
- cpu_err  output  1  one-cycle pulse with valid on timeout abort
- bus_req  output  1  backing-memory request
- bus_we  output  1  1 = write
- bus_addr  output  32  word-aligned address
- bus_wdata  output  32  write data
- bus_ack  input  1  transfer complete
- bus_rdata  input  32  read data, valid with bus_ack

Behaviour:
- Reset (async, immediate): all outputs 0, FSM -> IDLE, last_grant -> INSTR, so data wins the first tie.
- FSM states: IDLE, D_BUS, I_BUS, D_RSP, I_RSP.
- Pending conditions: data pending = cpu_rd|cpu_wr; fetch pending = cpu_instr_req.
- cpu_rd&cpu_wr together is treated as a write.
- IDLE, one pending: grant it.
- IDLE, both pending: grant the port not granted last (round-robin); update last_grant on grant.
- Grant action: latch address, we and wdata; next state D_BUS/I_BUS; bus_req=1 registered, so it is visible the cycle after the sample.
- bus_addr = {addr[31:2],2'b00}; low address bits are ignored.
- D_BUS/I_BUS: bus_req, bus_we, bus_addr, bus_wdata held stable until bus_ack is sampled high.
- On ack: bus_req=0 next cycle; rdata latched; go to D_RSP/I_RSP.
- D_RSP/I_RSP: assert the matching valid for exactly one cycle; cpu_rd_data/cpu_instr_data hold the latched value until the next completion of that port; then return to IDLE.
- Minimum latency: request sampled at cycle 0, bus_req high at cycle 1, ack at cycle 1, valid at cycle 2.
- Re-arm: IDLE re-samples the cycle after valid, so a request still asserted there is a new request. The requester must advance or drop its request on valid.
- Write completion: cpu_valid pulses; cpu_rd_data unchanged.
- bus_ack while bus_req=0 is ignored.
- Timeout (TIMEOUT>0): a wait counter clears on grant and increments each BUS cycle without ack. When it reaches TIMEOUT:
  - drop bus_req;
  - go to RSP with err flag set;
  - pulse valid together with cpu_err (data port) or instr_valid with cpu_err (fetch port);
  - read data = ERR_DATA.
- Timeout counter width: clog2(TIMEOUT+1); no wrap.
- Request inputs are not sampled outside IDLE; requests arriving during a transfer wait.

Optional Feature:
- Macro: MEM_FETCH_BUF_EN.
- Defined:
  - One-entry fetch buffer holds the tag (addr[31:2]), data and a valid bit.
  - IDLE with fetch pending, tag hit and no data grant this cycle -> I_RSP directly, no bus transaction (latency 1 cycle).
  - Filled on every non-error fetch completion.
  - Invalidated when a data write to the same word is granted, and on reset.
  - Round-robin state is not updated on a hit.
- Undefined: every fetch goes to the bus; no buffer storage exists.

Test Plan:
- Single read: cpu_rd, addr 0x0000_0013, bus_ack one cycle after bus_req with rdata 0xCAFE_F00D -> bus_addr 0x0000_0010, bus_we=0, cpu_valid pulses once at cycle 2 with rd_data 0xCAFE_F00D, cpu_err=0.
- Write with 3-cycle ack delay: cpu_wr, addr 0x100, data 0x1234_5678 -> bus_req/bus_we/bus_wdata stable for 3 cycles, cpu_valid one pulse, bus_req low the cycle after ack.
- Simultaneous fetch + read held continuously after reset -> grant order data, instr, data, instr; neither port starves.
- Timeout: TIMEOUT=4, no ack -> bus_req drops after 4 wait cycles, cpu_valid and cpu_err pulse together, rd_data=ERR_DATA.
- Async reset asserted mid-transfer in D_BUS -> bus_req and all outputs 0 immediately; after release a fresh fetch to 0x0 completes normally.
- MEM_FETCH_BUF_EN: fetch 0x40 twice -> second completes with no bus_req. Then write 0x40 and fetch 0x40 again -> bus transaction reissued, returns the new data.

Source files
------------

// File: rtl/mem_arbiter_ctrl_if.sv
// CPU-side and backing-memory signal bundle for mem_arbiter_ctrl.
// master = CPU/memory environment, slave = the arbiter itself.
interface mem_arbiter_ctrl_if;
  logic        cpu_instr_req;
  logic [31:0] cpu_instr_addr;
  logic [31:0] cpu_instr_data;
  logic        cpu_instr_valid;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wr_data;
  logic [31:0] cpu_rd_data;
  logic        cpu_valid;
  logic        cpu_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output cpu_instr_req, cpu_instr_addr, cpu_rd, cpu_wr, cpu_addr, cpu_wr_data,
           bus_ack, bus_rdata,
    input  cpu_instr_data, cpu_instr_valid, cpu_rd_data, cpu_valid, cpu_err,
           bus_req, bus_we, bus_addr, bus_wdata
  );

  modport slave (
    input  cpu_instr_req, cpu_instr_addr, cpu_rd, cpu_wr, cpu_addr, cpu_wr_data,
           bus_ack, bus_rdata,
    output cpu_instr_data, cpu_instr_valid, cpu_rd_data, cpu_valid, cpu_err,
           bus_req, bus_we, bus_addr, bus_wdata
  );
endinterface

// File: rtl/mem_arbiter_ctrl.sv
// Round-robin arbiter of CPU fetch and data ports onto one req/ack memory bus,
// with wait timeout. Define MEM_FETCH_BUF_EN for a one-entry fetch buffer.
module mem_arbiter_ctrl #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
  input logic               clk,
  input logic               rst_n,
  mem_arbiter_ctrl_if.slave mif
);

  localparam int unsigned WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WW-1:0] TO_LAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFFC;

  typedef enum logic [2:0] {IDLE, D_BUS, I_BUS, D_RSP, I_RSP} state_e;
  typedef enum logic {GNT_DATA, GNT_INSTR} grant_e;

  state_e        state_q;
  grant_e        last_grant_q;
  logic [WW-1:0] wait_q;
  logic          bus_req_q, bus_we_q;
  logic [31:0]   bus_addr_q, bus_wdata_q;
  logic          cpu_valid_q, cpu_err_q, instr_valid_q;
  logic [31:0]   cpu_rd_data_q, instr_data_q;

  logic grant_data, grant_instr, buf_hit, timed_out;

`ifdef MEM_FETCH_BUF_EN
  logic        fbuf_valid_q;
  logic [29:0] fbuf_tag_q;
  logic [31:0] fbuf_data_q;
`endif

  // NOTE: every variable gets a default before any condition so no latch is inferred.
  always_comb begin
    grant_data  = (mif.cpu_rd | mif.cpu_wr) &&
                  (!mif.cpu_instr_req || last_grant_q == GNT_INSTR);
    grant_instr = mif.cpu_instr_req && !grant_data;
    timed_out   = (TIMEOUT > 0) && (wait_q == TO_LAST);
    buf_hit     = 1'b0;
`ifdef MEM_FETCH_BUF_EN
    buf_hit     = fbuf_valid_q && (fbuf_tag_q == mif.cpu_instr_addr[31:2]);
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_grant_q  <= GNT_INSTR;
      wait_q        <= '0;
      bus_req_q     <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= '0;
      bus_wdata_q   <= '0;
      cpu_valid_q   <= 1'b0;
      cpu_err_q     <= 1'b0;
      instr_valid_q <= 1'b0;
      cpu_rd_data_q <= '0;
      instr_data_q  <= '0;
`ifdef MEM_FETCH_BUF_EN
      fbuf_valid_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_data) begin
            state_q      <= D_BUS;
            bus_req_q    <= 1'b1;
            bus_we_q     <= mif.cpu_wr;
            bus_addr_q   <= mif.cpu_addr & ADDR_MASK;
            bus_wdata_q  <= mif.cpu_wr_data;
            last_grant_q <= GNT_DATA;
            wait_q       <= '0;
`ifdef MEM_FETCH_BUF_EN
            if (mif.cpu_wr && fbuf_tag_q == mif.cpu_addr[31:2])
              fbuf_valid_q <= 1'b0;
`endif
          end else if (grant_instr && buf_hit) begin
            // Buffer hit: answer without a bus transaction, round-robin untouched.
            state_q       <= I_RSP;
            instr_valid_q <= 1'b1;
`ifdef MEM_FETCH_BUF_EN
            instr_data_q  <= fbuf_data_q;
`endif
          end else if (grant_instr) begin
            state_q      <= I_BUS;
            bus_req_q    <= 1'b1;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= mif.cpu_instr_addr & ADDR_MASK;
            last_grant_q <= GNT_INSTR;
            wait_q       <= '0;
          end
        end
        D_BUS, I_BUS: begin
          if (mif.bus_ack) begin
            bus_req_q <= 1'b0;
            if (state_q == D_BUS) begin
              state_q     <= D_RSP;
              cpu_valid_q <= 1'b1;
              if (!bus_we_q) cpu_rd_data_q <= mif.bus_rdata;
            end else begin
              state_q       <= I_RSP;
              instr_valid_q <= 1'b1;
              instr_data_q  <= mif.bus_rdata;
`ifdef MEM_FETCH_BUF_EN
              fbuf_valid_q  <= 1'b1;
`endif
            end
          end else if (timed_out) begin
            bus_req_q <= 1'b0;
            cpu_err_q <= 1'b1;
            if (state_q == D_BUS) begin
              state_q     <= D_RSP;
              cpu_valid_q <= 1'b1;
              if (!bus_we_q) cpu_rd_data_q <= ERR_DATA;
            end else begin
              state_q       <= I_RSP;
              instr_valid_q <= 1'b1;
              instr_data_q  <= ERR_DATA;
            end
          end else if (TIMEOUT > 0) begin
            wait_q <= wait_q + WW'(1);
          end
        end
        D_RSP, I_RSP: begin
          cpu_valid_q   <= 1'b0;
          instr_valid_q <= 1'b0;
          cpu_err_q     <= 1'b0;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MEM_FETCH_BUF_EN
  // NOTE: buffer tag/data need no reset; the reset valid bit guards them.
  always_ff @(posedge clk) begin
    if (state_q == I_BUS && mif.bus_ack) begin
      fbuf_tag_q  <= bus_addr_q[31:2];
      fbuf_data_q <= mif.bus_rdata;
    end
  end
`endif

  assign mif.bus_req         = bus_req_q;
  assign mif.bus_we          = bus_we_q;
  assign mif.bus_addr        = bus_addr_q;
  assign mif.bus_wdata       = bus_wdata_q;
  assign mif.cpu_valid       = cpu_valid_q;
  assign mif.cpu_err         = cpu_err_q;
  assign mif.cpu_rd_data     = cpu_rd_data_q;
  assign mif.cpu_instr_valid = instr_valid_q;
  assign mif.cpu_instr_data  = instr_data_q;

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Directed bench for mem_arbiter_ctrl: per-cycle vector table plus sequences for
// timeout, async reset and the MEM_FETCH_BUF_EN fetch buffer.
module tb_mem_arbiter_ctrl;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam logic [31:0] ERRV = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mem_arbiter_ctrl_if mif ();

  mem_arbiter_ctrl #(.TIMEOUT(4), .ERR_DATA(ERRV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mif   (mif)
  );

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        rd, wr;
    logic [31:0] a, wd;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req, e_we;
    logic [31:0] e_addr, e_wdata;
    logic        e_v, e_err, e_iv;
    logic [31:0] e_rd, e_id;
  } vec_t;

  vec_t vec [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd, input logic ack,
                       input logic [31:0] rdata);
    mif.cpu_instr_req  = ir;
    mif.cpu_instr_addr = ia;
    mif.cpu_rd         = rd;
    mif.cpu_wr         = wr;
    mif.cpu_addr       = a;
    mif.cpu_wr_data    = wd;
    mif.bus_ack        = ack;
    mif.bus_rdata      = rdata;
  endtask

  task automatic idle_inputs();
    drive(L, 32'h0, L, L, 32'h0, 32'h0, L, 32'h0);
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Arbitration: fetch + read held together, ack always high.
    vec[0]  = '{H, 32'h200, H, L, 32'h300, 32'h0, H, 32'hEEEE_EEEE, H, L, 32'h300, 32'h0, L, L, L, 32'h0, 32'h0};
    vec[1]  = '{H, 32'h200, H, L, 32'h300, 32'h0, H, 32'hD0D0_0001, L, L, 32'h0, 32'h0, H, L, L, 32'hD0D0_0001, 32'h0};
    vec[2]  = '{H, 32'h200, H, L, 32'h300, 32'h0, H, 32'h0, L, L, 32'h0, 32'h0, L, L, L, 32'hD0D0_0001, 32'h0};
    vec[3]  = '{H, 32'h200, H, L, 32'h300, 32'h0, H, 32'h0, H, L, 32'h200, 32'h0, L, L, L, 32'hD0D0_0001, 32'h0};
    vec[4]  = '{H, 32'h200, H, L, 32'h300, 32'h0, H, 32'h1A1A_0001, L, L, 32'h0, 32'h0, L, L, H, 32'hD0D0_0001, 32'h1A1A_0001};
    vec[5]  = '{H, 32'h204, H, L, 32'h300, 32'h0, H, 32'h0, L, L, 32'h0, 32'h0, L, L, L, 32'hD0D0_0001, 32'h1A1A_0001};
    vec[6]  = '{H, 32'h204, H, L, 32'h300, 32'h0, H, 32'h0, H, L, 32'h300, 32'h0, L, L, L, 32'hD0D0_0001, 32'h1A1A_0001};
    vec[7]  = '{H, 32'h204, H, L, 32'h300, 32'h0, H, 32'hD0D0_0002, L, L, 32'h0, 32'h0, H, L, L, 32'hD0D0_0002, 32'h1A1A_0001};
    vec[8]  = '{H, 32'h204, H, L, 32'h300, 32'h0, H, 32'h0, L, L, 32'h0, 32'h0, L, L, L, 32'hD0D0_0002, 32'h1A1A_0001};
    vec[9]  = '{H, 32'h204, H, L, 32'h300, 32'h0, H, 32'h0, H, L, 32'h204, 32'h0, L, L, L, 32'hD0D0_0002, 32'h1A1A_0001};
    vec[10] = '{H, 32'h204, H, L, 32'h300, 32'h0, H, 32'h1A1A_0002, L, L, 32'h0, 32'h0, L, L, H, 32'hD0D0_0002, 32'h1A1A_0002};
    vec[11] = '{L, 32'h0, L, L, 32'h0, 32'h0, L, 32'h0, L, L, 32'h0, 32'h0, L, L, L, 32'hD0D0_0002, 32'h1A1A_0002};
    // Single read with unaligned address, ack one cycle after bus_req.
    vec[12] = '{L, 32'h0, H, L, 32'h13, 32'h0, L, 32'h0, H, L, 32'h10, 32'h0, L, L, L, 32'hD0D0_0002, 32'h1A1A_0002};
    vec[13] = '{L, 32'h0, H, L, 32'h13, 32'h0, H, 32'hCAFE_F00D, L, L, 32'h0, 32'h0, H, L, L, 32'hCAFE_F00D, 32'h1A1A_0002};
    vec[14] = '{L, 32'h0, L, L, 32'h0, 32'h0, L, 32'h0, L, L, 32'h0, 32'h0, L, L, L, 32'hCAFE_F00D, 32'h1A1A_0002};
    // Write with ack on the third bus_req cycle; rd_data must not change.
    vec[15] = '{L, 32'h0, L, H, 32'h100, 32'h1234_5678, L, 32'h0, H, H, 32'h100, 32'h1234_5678, L, L, L, 32'hCAFE_F00D, 32'h1A1A_0002};
    vec[16] = '{L, 32'h0, L, H, 32'h100, 32'h1234_5678, L, 32'h0, H, H, 32'h100, 32'h1234_5678, L, L, L, 32'hCAFE_F00D, 32'h1A1A_0002};
    vec[17] = '{L, 32'h0, L, H, 32'h100, 32'h1234_5678, L, 32'h0, H, H, 32'h100, 32'h1234_5678, L, L, L, 32'hCAFE_F00D, 32'h1A1A_0002};
    vec[18] = '{L, 32'h0, L, H, 32'h100, 32'h1234_5678, H, 32'hFFFF_FFFF, L, L, 32'h0, 32'h0, H, L, L, 32'hCAFE_F00D, 32'h1A1A_0002};
    // Stray ack in IDLE is ignored.
    vec[19] = '{L, 32'h0, L, L, 32'h0, 32'h0, H, 32'h1111_1111, L, L, 32'h0, 32'h0, L, L, L, 32'hCAFE_F00D, 32'h1A1A_0002};

    idle_inputs();
    #12;
    check("reset bus_req", {31'b0, mif.bus_req}, 32'h0);
    check("reset cpu_valid", {31'b0, mif.cpu_valid}, 32'h0);
    check("reset instr_valid", {31'b0, mif.cpu_instr_valid}, 32'h0);
    check("reset cpu_err", {31'b0, mif.cpu_err}, 32'h0);
    check("reset rd_data", mif.cpu_rd_data, 32'h0);
    check("reset bus_addr", mif.bus_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(vec[i].ir, vec[i].ia, vec[i].rd, vec[i].wr, vec[i].a, vec[i].wd, vec[i].ack, vec[i].rdata);
      step();
      check($sformatf("v%0d bus_req", i), {31'b0, mif.bus_req}, {31'b0, vec[i].e_req});
      check($sformatf("v%0d cpu_valid", i), {31'b0, mif.cpu_valid}, {31'b0, vec[i].e_v});
      check($sformatf("v%0d cpu_err", i), {31'b0, mif.cpu_err}, {31'b0, vec[i].e_err});
      check($sformatf("v%0d instr_valid", i), {31'b0, mif.cpu_instr_valid}, {31'b0, vec[i].e_iv});
      check($sformatf("v%0d rd_data", i), mif.cpu_rd_data, vec[i].e_rd);
      check($sformatf("v%0d instr_data", i), mif.cpu_instr_data, vec[i].e_id);
      if (vec[i].e_req) begin
        check($sformatf("v%0d bus_we", i), {31'b0, mif.bus_we}, {31'b0, vec[i].e_we});
        check($sformatf("v%0d bus_addr", i), mif.bus_addr, vec[i].e_addr);
        if (vec[i].e_we)
          check($sformatf("v%0d bus_wdata", i), mif.bus_wdata, vec[i].e_wdata);
      end
    end

    // Data read timeout: bus_req for 4 cycles, then valid+err with ERR_DATA.
    @(negedge clk);
    drive(L, 32'h0, H, L, 32'h400, 32'h0, L, 32'h0);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("to_rd wait%0d bus_req", k), {31'b0, mif.bus_req}, 32'h1);
    end
    step();
    check("to_rd bus_req drop", {31'b0, mif.bus_req}, 32'h0);
    check("to_rd cpu_valid", {31'b0, mif.cpu_valid}, 32'h1);
    check("to_rd cpu_err", {31'b0, mif.cpu_err}, 32'h1);
    check("to_rd rd_data", mif.cpu_rd_data, ERRV);
    @(negedge clk);
    idle_inputs();
    step();
    check("to_rd valid end", {30'b0, mif.cpu_valid, mif.cpu_err}, 32'h0);

    // Fetch timeout.
    @(negedge clk);
    drive(H, 32'h480, L, L, 32'h0, 32'h0, L, 32'h0);
    for (int k = 0; k < 4; k++) step();
    check("to_if bus_req pre-drop", {31'b0, mif.bus_req}, 32'h1);
    step();
    check("to_if instr_valid+err", {29'b0, mif.cpu_instr_valid, mif.cpu_err, mif.cpu_valid}, 32'h6);
    check("to_if instr_data", mif.cpu_instr_data, ERRV);
    @(negedge clk);
    idle_inputs();
    step();

    // Async reset in the middle of a D_BUS write.
    @(negedge clk);
    drive(L, 32'h0, L, H, 32'h500, 32'h5555_5555, L, 32'h0);
    step();
    check("rst bus_req before", {31'b0, mif.bus_req}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst bus_req now", {31'b0, mif.bus_req}, 32'h0);
    check("rst bus_we now", {31'b0, mif.bus_we}, 32'h0);
    check("rst bus_addr now", mif.bus_addr, 32'h0);
    check("rst rd_data now", mif.cpu_rd_data, 32'h0);
    check("rst instr_data now", mif.cpu_instr_data, 32'h0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(H, 32'h0, L, L, 32'h0, 32'h0, L, 32'h0);
    step();
    check("post-rst fetch bus_req", {31'b0, mif.bus_req}, 32'h1);
    check("post-rst fetch bus_addr", mif.bus_addr, 32'h0);
    @(negedge clk);
    drive(H, 32'h0, L, L, 32'h0, 32'h0, H, 32'h0000_600D);
    step();
    check("post-rst fetch valid", {31'b0, mif.cpu_instr_valid}, 32'h1);
    check("post-rst fetch data", mif.cpu_instr_data, 32'h0000_600D);
    @(negedge clk);
    idle_inputs();
    step();
    check("post-rst valid end", {31'b0, mif.cpu_instr_valid}, 32'h0);

    // Fetch buffer: fetch 0x40 twice, write 0x40, fetch 0x40 again.
    @(negedge clk);
    drive(H, 32'h40, L, L, 32'h0, 32'h0, L, 32'h0);
    step();
    check("fb1 bus_addr", mif.bus_req ? mif.bus_addr : 32'hFFFF_FFFF, 32'h40);
    @(negedge clk);
    drive(H, 32'h40, L, L, 32'h0, 32'h0, H, 32'hAAAA_0040);
    step();
    check("fb1 data", mif.cpu_instr_valid ? mif.cpu_instr_data : 32'hFFFF_FFFF, 32'hAAAA_0040);
    @(negedge clk);
    idle_inputs();
    step();
    @(negedge clk);
    drive(H, 32'h40, L, L, 32'h0, 32'h0, L, 32'h0);
    step();
`ifdef MEM_FETCH_BUF_EN
    check("fb2 hit no bus_req", {31'b0, mif.bus_req}, 32'h0);
    check("fb2 hit valid", {31'b0, mif.cpu_instr_valid}, 32'h1);
    check("fb2 hit data", mif.cpu_instr_data, 32'hAAAA_0040);
`else
    check("fb2 bus_req", {31'b0, mif.bus_req}, 32'h1);
    @(negedge clk);
    drive(H, 32'h40, L, L, 32'h0, 32'h0, H, 32'hAAAA_0040);
    step();
    check("fb2 valid", {31'b0, mif.cpu_instr_valid}, 32'h1);
    check("fb2 data", mif.cpu_instr_data, 32'hAAAA_0040);
`endif
    @(negedge clk);
    idle_inputs();
    step();
    @(negedge clk);
    drive(L, 32'h0, L, H, 32'h40, 32'hBBBB_0040, L, 32'h0);
    step();
    check("fbw bus_we", {31'b0, mif.bus_we}, 32'h1);
    @(negedge clk);
    drive(L, 32'h0, L, H, 32'h40, 32'hBBBB_0040, H, 32'h0);
    step();
    check("fbw valid", {31'b0, mif.cpu_valid}, 32'h1);
    @(negedge clk);
    idle_inputs();
    step();
    @(negedge clk);
    drive(H, 32'h40, L, L, 32'h0, 32'h0, L, 32'h0);
    step();
    check("fb3 reissued bus_req", {31'b0, mif.bus_req}, 32'h1);
    check("fb3 no early valid", {31'b0, mif.cpu_instr_valid}, 32'h0);
    @(negedge clk);
    drive(H, 32'h40, L, L, 32'h0, 32'h0, H, 32'hBBBB_0040);
    step();
    check("fb3 valid", {31'b0, mif.cpu_instr_valid}, 32'h1);
    check("fb3 new data", mif.cpu_instr_data, 32'hBBBB_0040);
    @(negedge clk);
    idle_inputs();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
